// File: rtl/sound_mixer.sv
// Sample-playback mixer: walks the active channels once per 256-CLK period, fetches, scales and sums one sample each.
// Latency: soundData updates 3 + sum(per-channel cost) CLK after the period tick; active channel 4 CLK + ROM waits, idle channel 2 CLK.
// Backpressure: ROM req/ack stalls FETCH indefinitely; a tick that lands mid-mix is dropped and flagged on overrun.
//
// Ports: CLK/XRST (async active-low) | trig, loop, ch_base, ch_len, ch_vol: per-channel packed controls
//        rom_req/rom_addr/rom_ack/rom_data: shared sample ROM handshake | soundData: mixed output word
//        ch_active: channels playing | overrun: one-CLK pulse on a dropped tick
// Build option: define SOUND_MIXER_SAT_EN to clamp the mix to 16-bit signed range instead of wrapping.
module sound_mixer #(
    parameter int NCH    = 4,
    parameter int ADDR_W = 16
) (
    input  logic                  CLK,
    input  logic                  XRST,
    input  logic [NCH-1:0]        trig,
    input  logic [NCH-1:0]        loop,
    input  logic [NCH*ADDR_W-1:0] ch_base,
    input  logic [NCH*ADDR_W-1:0] ch_len,
    input  logic [NCH*4-1:0]      ch_vol,
    output logic                  rom_req,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic                  rom_ack,
    input  logic [7:0]            rom_data,
    output logic [15:0]           soundData,
    output logic [NCH-1:0]        ch_active,
    output logic                  overrun
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_SCAN   = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_ACCUM  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_OUTPUT = 3'd6;

    localparam int              CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    logic [7:0]              tick_cnt;
    logic                    tick;
    logic                    accept;
    logic [2:0]              state;
    logic [CH_W-1:0]         ch;
    logic [NCH-1:0]          pend;
    logic [ADDR_W-1:0]       offset [NCH];
    logic signed [17:0]      acc;
    logic [7:0]              smp;

    logic [ADDR_W-1:0]       base_sel;
    logic [ADDR_W-1:0]       len_sel;
    logic [ADDR_W-1:0]       off_sel;
    logic [3:0]              vol_sel;
    logic signed [12:0]      prod;
    logic signed [17:0]      scaled;
    logic [15:0]             mix_out;

    assign tick   = (tick_cnt == 8'hFF);
    // Ticks are only honoured between mixes; one landing mid-mix is dropped.
    assign accept = tick && (state == S_IDLE);

    assign base_sel = ch_base[int'(ch)*ADDR_W +: ADDR_W];
    assign len_sel  = ch_len[int'(ch)*ADDR_W +: ADDR_W];
    assign vol_sel  = ch_vol[int'(ch)*4 +: 4];
    assign off_sel  = offset[ch];

    // Signed sample times unsigned volume (zero-extended so it stays positive), then x16.
    assign prod   = $signed(smp) * $signed({1'b0, vol_sel});
    assign scaled = {prod[12], prod, 4'b0000};

    always_comb begin
        mix_out = acc[15:0];
`ifdef SOUND_MIXER_SAT_EN
        if (acc > 18'sd32767) begin
            mix_out = 16'h7FFF;
        end else if (acc < -18'sd32768) begin
            mix_out = 16'h8000;
        end
`endif
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            tick_cnt  <= '0;
            state     <= S_IDLE;
            ch        <= '0;
            pend      <= '0;
            acc       <= '0;
            smp       <= '0;
            rom_req   <= 1'b0;
            rom_addr  <= '0;
            soundData <= '0;
            ch_active <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                offset[i] <= '0;
            end
        end else begin
            tick_cnt <= tick_cnt + 8'd1;
            overrun  <= tick && (state != S_IDLE);

            // Pending triggers are consumed only by an accepted tick; zero-length
            // requests are swallowed without touching the channel.
            if (accept) begin
                for (int i = 0; i < NCH; i++) begin
                    if (pend[i] && (ch_len[i*ADDR_W +: ADDR_W] != '0)) begin
                        offset[i]    <= '0;
                        ch_active[i] <= 1'b1;
                    end
                end
                pend <= trig;
            end else begin
                pend <= pend | trig;
            end

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    acc   <= '0;
                    ch    <= '0;
                    state <= S_SCAN;
                end
                S_SCAN: begin
                    if (ch_active[ch]) begin
                        rom_req  <= 1'b1;
                        rom_addr <= base_sel + off_sel;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_FETCH: begin
                    if (rom_ack) begin
                        smp     <= rom_data;
                        rom_req <= 1'b0;
                        state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc + scaled;
                    if (off_sel == len_sel - ADDR_W'(1)) begin
                        offset[ch] <= '0;
                        if (!loop[ch]) begin
                            ch_active[ch] <= 1'b0;
                        end
                    end else begin
                        offset[ch] <= off_sel + ADDR_W'(1);
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (ch == LAST_CH) begin
                        state <= S_OUTPUT;
                    end else begin
                        ch    <= ch + CH_W'(1);
                        state <= S_SCAN;
                    end
                end
                S_OUTPUT: begin
                    soundData <= mix_out;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_mixer.sv
module tb_sound_mixer;

    localparam int NCH    = 4;
    localparam int ADDR_W = 16;
    localparam int K_SD   = 0;
    localparam int K_ACT  = 1;
    localparam int K_REQ  = 2;
    localparam int K_OVR  = 3;

    logic                  CLK = 1'b0;
    logic                  XRST = 1'b0;
    logic [NCH-1:0]        trig = '0;
    logic [NCH-1:0]        loop = '0;
    logic [NCH*ADDR_W-1:0] ch_base = '0;
    logic [NCH*ADDR_W-1:0] ch_len = '0;
    logic [NCH*4-1:0]      ch_vol = '0;
    logic                  rom_req;
    logic [ADDR_W-1:0]     rom_addr;
    logic                  rom_ack = 1'b0;
    logic [7:0]            rom_data = '0;
    logic [15:0]           soundData;
    logic [NCH-1:0]        ch_active;
    logic                  overrun;

    sound_mixer #(.NCH(NCH), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .XRST(XRST), .trig(trig), .loop(loop),
        .ch_base(ch_base), .ch_len(ch_len), .ch_vol(ch_vol),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .soundData(soundData), .ch_active(ch_active), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t              exp_q[$];
    logic [15:0]       addr_q[$];
    logic [7:0]        mem [0:65535];
    int                cyc = 0;
    int                wait_n = 0;
    int                wcnt = 0;
    int                total = 0;
    int                bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Expected responses, kept sorted by cycle.
    task automatic expect_at(input int c, input int k, input logic [31:0] v);
        exp_t e;
        int idx;
        e.cyc = c; e.kind = k; e.val = v;
        idx = exp_q.size();
        while (idx > 0 && exp_q[idx-1].cyc > c) idx--;
        exp_q.insert(idx, e);
    endtask

    // Cycle count since reset release; mirrors the free-running tick counter.
    always @(posedge CLK) begin
        if (!XRST) cyc = 0;
        else       cyc = cyc + 1;
    end

    // Monitor: compares outputs at scheduled cycles, away from the active edge.
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            case (e.kind)
                K_SD:    check($sformatf("soundData@%0d", e.cyc), {16'h0, soundData}, e.val);
                K_ACT:   check($sformatf("ch_active@%0d", e.cyc), {28'h0, ch_active}, e.val);
                K_REQ:   check($sformatf("rom_req@%0d", e.cyc), {31'h0, rom_req}, e.val);
                default: check($sformatf("overrun@%0d", e.cyc), {31'h0, overrun}, e.val);
            endcase
        end
    end

    // ROM model: acks after wait_n cycles of request and checks the address against the expected fetch order.
    always @(negedge CLK) begin
        if (rom_req) begin
            if (wcnt >= wait_n) begin
                rom_ack  = 1'b1;
                rom_data = mem[rom_addr];
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rom_addr_unexpected: got %h want none @%0d", rom_addr, cyc);
                end else begin
                    check($sformatf("rom_addr@%0d", cyc), {16'h0, rom_addr}, {16'h0, addr_q.pop_front()});
                end
            end else begin
                rom_ack = 1'b0;
                wcnt++;
            end
        end else begin
            rom_ack = 1'b0;
            wcnt    = 0;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic set_ch(input int i, input logic [15:0] b, input logic [15:0] l,
                          input logic [3:0] v, input logic lp);
        ch_base[i*16 +: 16] = b;
        ch_len[i*16 +: 16]  = l;
        ch_vol[i*4 +: 4]    = v;
        loop[i]             = lp;
    endtask

    task automatic pulse_trig(input int c, input logic [NCH-1:0] m);
        wait_until(c);
        trig = m;
        @(negedge CLK);
        trig = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        XRST = 1'b0; trig = '0; loop = '0; ch_base = '0; ch_len = '0; ch_vol = '0; wait_n = 0;
        repeat (3) @(negedge CLK);
        check("rst_soundData", {16'h0, soundData}, 32'h0);
        check("rst_ch_active", {28'h0, ch_active}, 32'h0);
        check("rst_rom_req",   {31'h0, rom_req}, 32'h0);
        check("rst_rom_addr",  {16'h0, rom_addr}, 32'h0);
        check("rst_overrun",   {31'h0, overrun}, 32'h0);
        XRST = 1'b1;
    endtask

    task automatic drain(input string name);
        check({name, "_exp_left"},  exp_q.size(), 0);
        check({name, "_addr_left"}, addr_q.size(), 0);
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle after reset: mixes run with nothing active and produce 0.
        do_reset();
        expect_at(300, K_SD, 0);
        expect_at(600, K_SD, 0);
        expect_at(600, K_REQ, 0);
        wait_until(610);
        drain("idle");

        // One-shot channel 0: first tick at 255, mix starts 256, output at 268.
        do_reset();
        mem[16'h100] = 8'h10; mem[16'h101] = 8'h20; mem[16'h102] = 8'h7F;
        set_ch(0, 16'h100, 16'd3, 4'd15, 1'b0);
        expect_at(255, K_ACT, 4'b0000);
        expect_at(256, K_ACT, 4'b0001);
        expect_at(257, K_REQ, 0);
        expect_at(258, K_REQ, 1);
        expect_at(259, K_REQ, 0);
        expect_at(267, K_SD, 16'h0000);
        expect_at(268, K_SD, 16'h0F00);
        expect_at(523, K_SD, 16'h0F00);
        expect_at(524, K_SD, 16'h1E00);
        expect_at(524, K_ACT, 4'b0001);
        expect_at(780, K_SD, 16'h7710);
        expect_at(780, K_ACT, 4'b0000);
        expect_at(1036, K_SD, 16'h0000);
        addr_q = '{16'h100, 16'h101, 16'h102};
        pulse_trig(10, 4'b0001);
        wait_until(1040);
        drain("single");

        // Looping channel 0 wraps its offset and stays active.
        do_reset();
        set_ch(0, 16'h100, 16'd3, 4'd15, 1'b1);
        expect_at(268,  K_SD, 16'h0F00);
        expect_at(524,  K_SD, 16'h1E00);
        expect_at(780,  K_SD, 16'h7710);
        expect_at(1036, K_SD, 16'h0F00);
        expect_at(1292, K_SD, 16'h1E00);
        expect_at(1292, K_ACT, 4'b0001);
        addr_q = '{16'h100, 16'h101, 16'h102, 16'h100, 16'h101};
        pulse_trig(10, 4'b0001);
        wait_until(1300);
        drain("loop");

        // Four full-scale channels: positive then negative overflow of 16 bits.
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            set_ch(i, 16'h200 + 16'(i*16), 16'd1, 4'd15, 1'b0);
            mem[16'h200 + 16'(i*16)] = 8'h7F;
            mem[16'h300 + 16'(i*16)] = 8'h80;
        end
`ifdef SOUND_MIXER_SAT_EN
        expect_at(274, K_SD, 16'h7FFF);
        expect_at(530, K_SD, 16'h8000);
`else
        expect_at(274, K_SD, 16'hDC40);
        expect_at(530, K_SD, 16'h2000);
`endif
        expect_at(274, K_ACT, 4'b0000);
        addr_q = '{16'h200, 16'h210, 16'h220, 16'h230, 16'h300, 16'h310, 16'h320, 16'h330};
        pulse_trig(10, 4'b1111);
        wait_until(300);
        for (int i = 0; i < NCH; i++) set_ch(i, 16'h300 + 16'(i*16), 16'd1, 4'd15, 1'b0);
        pulse_trig(300, 4'b1111);
        wait_until(540);
        drain("sat");

        // Slow ROM: each mix takes 418 CLK, so every second tick is dropped.
        do_reset();
        wait_n = 100;
        for (int i = 0; i < NCH; i++) begin
            set_ch(i, 16'h400 + 16'(i), 16'd1, 4'd1, 1'b1);
            mem[16'h400 + 16'(i)] = 8'(i + 1);
        end
        expect_at(511,  K_OVR, 0);
        expect_at(512,  K_OVR, 1);
        expect_at(513,  K_OVR, 0);
        expect_at(673,  K_SD, 16'h0000);
        expect_at(674,  K_SD, 16'h00A0);
        expect_at(930,  K_SD, 16'h00A0);
        expect_at(1024, K_OVR, 1);
        expect_at(1185, K_SD, 16'h00A0);
        expect_at(1186, K_SD, 16'h0140);
        expect_at(1280, K_OVR, 0);
        expect_at(1282, K_REQ, 1);
        addr_q = '{16'h400, 16'h401, 16'h402, 16'h403, 16'h400, 16'h401, 16'h402, 16'h403};
        pulse_trig(10, 4'b1111);
        wait_until(700);
        for (int i = 0; i < NCH; i++) ch_vol[i*4 +: 4] = 4'd2;
        wait_until(1300);
        check("midfetch_req_before", {31'h0, rom_req}, 1);
        XRST = 1'b0;
        #1;
        check("midfetch_req_after", {31'h0, rom_req}, 0);
        check("midfetch_active_after", {28'h0, ch_active}, 0);
        drain("overrun");

        // Retrigger of ch1 restarts at its base; zero-length ch2 never plays.
        do_reset();
        mem[16'h500] = 8'd1; mem[16'h501] = 8'd2; mem[16'h502] = 8'd3; mem[16'h503] = 8'd4;
        mem[16'h600] = 8'h55;
        set_ch(1, 16'h500, 16'd4, 4'd1, 1'b0);
        set_ch(2, 16'h600, 16'd0, 4'd1, 1'b0);
        expect_at(256,  K_ACT, 4'b0010);
        expect_at(268,  K_SD, 16'h0010);
        expect_at(524,  K_SD, 16'h0020);
        expect_at(780,  K_SD, 16'h0010);
        expect_at(780,  K_ACT, 4'b0010);
        expect_at(1036, K_SD, 16'h0020);
        expect_at(1036, K_ACT, 4'b0010);
        addr_q = '{16'h500, 16'h501, 16'h500, 16'h501};
        pulse_trig(10, 4'b0110);
        pulse_trig(600, 4'b0010);
        wait_until(1040);
        drain("retrig");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sound_mixer.md
# sound_mixer

Multi-channel sample-playback mixer feeding the 16-bit `soundData` input of the I2S-style parallel/serial output stage. Once per 44.1 kHz sample period it walks every active effect channel, fetches one signed 8-bit sample per channel from the shared sample ROM over a req/ack handshake, scales each sample by its channel volume, and sums the results. The 16-bit mixed word is held stable for the serializer. Effect triggers come from the game's sound-port decode logic.

## Interface
Parameters:
- `NCH`, 4: number of effect channels, 1–8.
- `ADDR_W`, 16: sample ROM address width.

Ports:
- `CLK` in 1: 11.2896 MHz system audio clock.
- `XRST` in 1: asynchronous, active-low reset.
- `trig` in NCH: per-channel start request, level-sampled every CLK.
- `loop` in NCH: per-channel loop enable, sampled when the channel reaches its end.
- `ch_base` in NCH*ADDR_W: packed per-channel ROM start address. Channel i uses bits [i*ADDR_W +: ADDR_W].
- `ch_len` in NCH*ADDR_W: packed per-channel length in samples.
- `ch_vol` in NCH*4: packed per-channel unsigned volume, 0–15.
- `rom_req` out 1: ROM read request.
- `rom_addr` out ADDR_W: ROM read address.
- `rom_ack` in 1: ROM data valid.
- `rom_data` in 8: signed sample.
- `soundData` out 16: mixed signed sample for the serializer.
- `ch_active` out NCH: channel is currently playing.
- `overrun` out 1: one-CLK pulse when a tick arrives before the mix has finished.

## Operation
- **Sample-period tick.** A free-running 8-bit counter resets to 0. `tick` is asserted when the counter equals 8'hFF, giving one tick every 256 CLK.
- **Trigger latching.** Any CLK with `trig[i]`=1 sets `pend[i]`.
- **Applying pending triggers.** On `tick`, for each set `pend[i]` with `ch_len[i]`≠0: `offset[i]`←0, `ch_active[i]`←1, `pend[i]` cleared. If `ch_len[i]`=0 the trigger is discarded, `pend[i]` is cleared, and the channel's state is unchanged.
- **FSM states:**
  - IDLE → INIT on `tick`. INIT clears `acc` (18-bit signed) and sets `ch`←0.
  - SCAN: if `ch_active[ch]`, go to FETCH. Otherwise skip to NEXT.
  - FETCH: drive `rom_req`=1 with `rom_addr`=`ch_base[ch]`+`offset[ch]` (wraps modulo 2^ADDR_W). Hold both stable until `rom_ack`. On `rom_ack`, capture `rom_data` and go to ACCUM.
  - ACCUM: `acc` += sign-extended(`rom_data` × `ch_vol[ch]`) << 4. Advance the offset: if `offset`=`ch_len`−1, then `offset`←0 when `loop[ch]`, else `ch_active[ch]`←0. Otherwise `offset`+1.
  - NEXT: `ch`+1. Go to SCAN, or to OUTPUT when `ch`=NCH−1.
  - OUTPUT: update `soundData` from `acc` (see Configuration). Return to IDLE.
- **No active channels.** The mix runs with all channels skipped and `soundData` becomes 0.
- **Overrun.**
  - `tick` while not in IDLE: pulse `overrun` and ignore that tick. The mix in progress completes normally.
  - Pending triggers stay latched until the next accepted tick.
- **Retrigger while active.** Restarts at offset 0 on the next accepted tick. The current mix is unaffected.

## Timing
- **Reset values:** `soundData`=0, `ch_active`=0, `rom_req`=0, `rom_addr`=0, `overrun`=0. `pend`, `offset`, the counter, and `acc` all reset to 0. The FSM resets to IDLE.
- **Handshake:**
  - `rom_ack` is valid only while `rom_req`=1. An ack received in the same cycle `rom_req` rises is legal.
  - `rom_req` drops in the cycle after ack.
  - `rom_ack` while `rom_req`=0 is ignored.
- **Latency:** each active channel costs 4 CLK plus the ROM wait states (SCAN, FETCH≥1, ACCUM, NEXT). An inactive channel costs 2 CLK. `soundData` changes exactly 3 + Σ(per-channel cost) CLK after `tick`.
- **Output stability:** `soundData` changes only in OUTPUT, at most once per 256 CLK.
- **Reset mid-fetch:** `rom_req` drops immediately. A late `rom_ack` after release is ignored.

## Configuration
- **`SOUND_MIXER_SAT_EN` defined:** OUTPUT clamps `acc` to the range [−32768, 32767].
- **`SOUND_MIXER_SAT_EN` undefined:** OUTPUT takes `acc[15:0]` (two's-complement wrap).

## Test plan
- **Reset:** `XRST` low, then release → all outputs 0, first `tick` at CLK 256, `soundData` stays 0 with no triggers.
- **Single channel:** ch0 base=0x100, len=3, vol=15, ROM returns 0x10, 0x20, 0x7F with 0-wait ack → `soundData` = 0x0F00, 0x1E00, 0x7710 on successive periods, then 0 and `ch_active[0]`=0.
- **Loop:** same setup with `loop[0]`=1 → the address sequence 0x100, 0x101, 0x102, 0x100 repeats and `ch_active[0]` stays 1.
- **Saturation:** 4 channels each returning 0x7F at vol 15 (sum 121920) → 0x7FFF with `SOUND_MIXER_SAT_EN`, 0xDC40 without. All channels returning 0x80 at vol 15 → 0x8000 with the macro.
- **Overrun:** ROM ack delayed 100 CLK, 4 channels active → `overrun` pulses once, the next tick is ignored, and `soundData` updates once per two periods.
- **Retrigger / zero length:** `trig[1]` mid-playback → ch1 address returns to its base on the next tick. `trig[2]` with `ch_len`=0 → `ch_active[2]` stays 0 and no ROM request is made.
